// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer. It synchronizes the panel switches and the 1 Hz tick,
// then runs the selected model's wash/rinse/dry phases, with an optional reservation delay.
module wash_sequencer #(
   parameter logic [6:0] WASH_T    = 7'd90,
   parameter logic [6:0] RINSE_T   = 7'd60,
   parameter logic [6:0] DRY_T     = 7'd30,
   parameter logic [6:0] ORDER_MAX = 7'd99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_1HZ,
   input  logic       power_light,
   input  logic       start,
   input  logic       model_choose,
   input  logic       clothes_add,
   input  logic       order_time,
   output logic [2:0] current_model,
   output logic [1:0] current_program,
   output logic [1:0] run_state,
   output logic [6:0] rest_time,
   output logic [6:0] phase_time,
   output logic       finish
);

   // state  | meaning
   // IDLE   | configuring model / reservation, waiting for start
   // DELAY  | counting down the reservation delay (rest_time)
   // RUN    | counting down phase_time of the current program
   // PAUSE  | frozen; start resumes to the state saved in resume_q
   // DONE   | program complete, finish asserted
   typedef enum logic [2:0] {S_IDLE, S_DELAY, S_RUN, S_PAUSE, S_DONE} state_t;

   localparam logic [1:0] RS_IDLE  = 2'b00;
   localparam logic [1:0] RS_RUN   = 2'b01;
   localparam logic [1:0] RS_PAUSE = 2'b10;

   localparam int I_TICK = 0, I_ORDER = 1, I_CLOTHES = 2, I_MODEL = 3, I_START = 4, I_POWER = 5;

   logic [5:0] sync1, sync2, hist;
   logic [1:0] arm_cnt;
   logic       armed;
   logic       power_on, tick, start_ev, model_ev, clothes_ev, order_ev;

   // Events stay masked until the synchronizer has filled, so reset release never looks like an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= '0;
         sync2   <= '0;
         hist    <= '0;
         arm_cnt <= '0;
      end else begin
         sync1 <= {power_light, start, model_choose, clothes_add, order_time, clk_1HZ};
         sync2 <= sync1;
         hist  <= sync2;
         if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
      end
   end

   assign armed      = (arm_cnt == 2'd3);
   assign power_on   = sync2[I_POWER];
   assign tick       = armed & sync2[I_TICK]    & ~hist[I_TICK];
   assign start_ev   = armed & (sync2[I_START]  ^  hist[I_START]);
   assign model_ev   = armed & sync2[I_MODEL]   & ~hist[I_MODEL];
   assign clothes_ev = armed & sync2[I_CLOTHES] & ~hist[I_CLOTHES];
   assign order_ev   = armed & sync2[I_ORDER]   & ~hist[I_ORDER];

   function automatic logic [6:0] phase_dur(input logic [1:0] prog);
      case (prog)
         2'd0:    phase_dur = WASH_T;
         2'd1:    phase_dur = RINSE_T;
         default: phase_dur = DRY_T;
      endcase
   endfunction

   // Bit 0 wash, bit 1 rinse, bit 2 dry.
   function automatic logic [2:0] phase_mask(input logic [2:0] model);
      case (model)
         3'd0:    phase_mask = 3'b111;
         3'd1:    phase_mask = 3'b001;
         3'd2:    phase_mask = 3'b011;
         3'd3:    phase_mask = 3'b010;
         3'd4:    phase_mask = 3'b110;
         3'd5:    phase_mask = 3'b100;
         default: phase_mask = 3'b111;
      endcase
   endfunction

   function automatic logic [1:0] first_phase(input logic [2:0] model);
      logic [2:0] m;
      m = phase_mask(model);
      if (m[0])      first_phase = 2'd0;
      else if (m[1]) first_phase = 2'd1;
      else           first_phase = 2'd2;
   endfunction

   state_t     state_q, state_d, resume_q, resume_d;
   logic [2:0] model_q, model_d, next_model, mask;
   logic [1:0] prog_q, prog_d, run_q, run_d, next_prog;
   logic [6:0] rest_q, rest_d, phase_q, phase_d;
   logic       finish_q, finish_d, has_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         resume_q <= S_RUN;
         model_q  <= 3'd0;
         prog_q   <= 2'd0;
         run_q    <= RS_IDLE;
         rest_q   <= 7'd0;
         phase_q  <= WASH_T;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
         model_q  <= model_d;
         prog_q   <= prog_d;
         run_q    <= run_d;
         rest_q   <= rest_d;
         phase_q  <= phase_d;
         finish_q <= finish_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      resume_d   = resume_q;
      model_d    = model_q;
      prog_d     = prog_q;
      run_d      = run_q;
      rest_d     = rest_q;
      phase_d    = phase_q;
      finish_d   = finish_q;
      mask       = phase_mask(model_q);
      next_model = (model_q >= 3'd5) ? 3'd0 : model_q + 3'd1;
      has_next   = 1'b0;
      next_prog  = 2'd2;
      if (prog_q == 2'd0 && mask[1]) begin
         has_next  = 1'b1;
         next_prog = 2'd1;
      end else if (prog_q != 2'd2 && mask[2]) begin
         has_next  = 1'b1;
         next_prog = 2'd2;
      end

      if (!power_on) begin
         state_d  = S_IDLE;
         resume_d = S_RUN;
         model_d  = 3'd0;
         prog_d   = 2'd0;
         run_d    = RS_IDLE;
         rest_d   = 7'd0;
         phase_d  = WASH_T;
         finish_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_ev) begin
                  state_d = (rest_q != 7'd0) ? S_DELAY : S_RUN;
                  run_d   = RS_RUN;
               end else begin
                  if (model_ev) begin
                     model_d = next_model;
                     prog_d  = first_phase(next_model);
                     phase_d = phase_dur(first_phase(next_model));
                  end
                  if (order_ev && rest_q < ORDER_MAX) rest_d = rest_q + 7'd1;
               end
            end
            S_DELAY: begin
               if (start_ev || clothes_ev) begin
                  state_d  = S_PAUSE;
                  resume_d = S_DELAY;
                  run_d    = RS_PAUSE;
               end else if (tick) begin
                  rest_d = rest_q - 7'd1;
                  if (rest_q <= 7'd1) begin
                     rest_d  = 7'd0;
                     state_d = S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (start_ev || clothes_ev) begin
                  state_d  = S_PAUSE;
                  resume_d = S_RUN;
                  run_d    = RS_PAUSE;
               end else if (tick) begin
                  if (phase_q > 7'd1) begin
                     phase_d = phase_q - 7'd1;
                  end else if (has_next) begin
                     prog_d  = next_prog;
                     phase_d = phase_dur(next_prog);
                  end else begin
                     state_d  = S_DONE;
                     phase_d  = 7'd0;
                     finish_d = 1'b1;
                  end
               end
            end
            S_PAUSE: begin
               if (start_ev) begin
                  state_d = resume_q;
                  run_d   = RS_RUN;
               end
            end
            S_DONE: begin
               finish_d = 1'b1;
               run_d    = RS_RUN;
               if (start_ev || model_ev) begin
                  state_d  = S_IDLE;
                  model_d  = 3'd0;
                  prog_d   = 2'd0;
                  run_d    = RS_IDLE;
                  rest_d   = 7'd0;
                  phase_d  = WASH_T;
                  finish_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign current_model   = model_q;
   assign current_program = prog_q;
   assign run_state       = run_q;
   assign rest_time       = rest_q;
   assign phase_time      = phase_q;
   assign finish          = finish_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer with short phase durations and a small reservation limit.
module tb_wash_sequencer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clk_1HZ = 1'b0, power_light = 1'b1, start = 1'b0;
   logic       model_choose = 1'b0, clothes_add = 1'b0, order_time = 1'b0;
   logic [2:0] current_model;
   logic [1:0] current_program, run_state;
   logic [6:0] rest_time, phase_time;
   logic       finish;

   wash_sequencer #(.WASH_T(7'd3), .RINSE_T(7'd2), .DRY_T(7'd2), .ORDER_MAX(7'd3)) dut (
      .clk(clk), .reset(reset), .clk_1HZ(clk_1HZ), .power_light(power_light), .start(start),
      .model_choose(model_choose), .clothes_add(clothes_add), .order_time(order_time),
      .current_model(current_model), .current_program(current_program), .run_state(run_state),
      .rest_time(rest_time), .phase_time(phase_time), .finish(finish));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] m;
      logic [1:0] p;
      logic [1:0] rs;
      logic [6:0] rt;
      logic [6:0] pt;
      logic       f;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   exp_t  e_mon, act;
   string n_mon;

   // Monitor: the outputs are level-valued, so any queued expectation is compared at the next negedge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e_mon = exp_q.pop_front();
         n_mon = name_q.pop_front();
         act   = '{current_model, current_program, run_state, rest_time, phase_time, finish};
         checks++;
         if (act !== e_mon) begin
            errors++;
            $display("FAIL %s: got model=%b prog=%b run=%b rest=%0d phase=%0d fin=%b, want model=%b prog=%b run=%b rest=%0d phase=%0d fin=%b",
                     n_mon, act.m, act.p, act.rs, act.rt, act.pt, act.f,
                     e_mon.m, e_mon.p, e_mon.rs, e_mon.rt, e_mon.pt, e_mon.f);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic expect_out(input string nm, input int m, input int p, input int rs,
                             input int rt, input int pt, input int f);
      exp_t e;
      e = '{m[2:0], p[1:0], rs[1:0], rt[6:0], pt[6:0], f[0]};
      exp_q.push_back(e);
      name_q.push_back(nm);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: scoreboard not drained, %0d pending, want 0", nm, exp_q.size());
         exp_q.delete();
         name_q.delete();
      end
   endtask

   task automatic toggle_start();
      @(negedge clk) start = ~start;
      cyc(4);
   endtask

   // which: 0 model_choose, 1 clothes_add, 2 order_time
   task automatic pulse(input int which);
      @(negedge clk);
      if (which == 0) model_choose = 1'b1; else if (which == 1) clothes_add = 1'b1; else order_time = 1'b1;
      cyc(4);
      @(negedge clk);
      model_choose = 1'b0; clothes_add = 1'b0; order_time = 1'b0;
      cyc(4);
   endtask

   task automatic tick(input bit with_start);
      @(negedge clk);
      clk_1HZ = 1'b1;
      if (with_start) start = ~start;
      cyc(4);
      @(negedge clk) clk_1HZ = 1'b0;
      cyc(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      cyc(2);
      expect_out("reset_state", 0, 0, 0, 0, 3, 0);
      @(negedge clk) reset = 1'b1;
      cyc(5);
      expect_out("after_release", 0, 0, 0, 0, 3, 0);

      // Full wash-rinse-dry program.
      toggle_start();
      expect_out("s1_start", 0, 0, 1, 0, 3, 0);
      tick(0); expect_out("s1_wash_2", 0, 0, 1, 0, 2, 0);
      tick(0); tick(0);
      expect_out("s1_rinse", 0, 1, 1, 0, 2, 0);
      tick(0); tick(0);
      expect_out("s1_dry", 0, 2, 1, 0, 2, 0);
      tick(0); expect_out("s1_dry_1", 0, 2, 1, 0, 1, 0);
      tick(0); expect_out("s1_done", 0, 2, 1, 0, 0, 1);
      toggle_start();
      expect_out("s6_done_exit", 0, 0, 0, 0, 3, 0);

      // Model selection.
      pulse(0); expect_out("s2_model1", 1, 0, 0, 0, 3, 0);
      pulse(0); pulse(0); pulse(0);
      expect_out("s2_model4", 4, 1, 0, 0, 2, 0);
      pulse(0); expect_out("s2_model5", 5, 2, 0, 0, 2, 0);
      pulse(0); expect_out("s2_wrap", 0, 0, 0, 0, 3, 0);
      pulse(0);
      toggle_start();
      pulse(0); pulse(2);
      expect_out("s2_run_ignore", 1, 0, 1, 0, 3, 0);
      tick(0); tick(0); tick(0);
      expect_out("s2_wash_only_done", 1, 0, 1, 0, 0, 1);
      pulse(0);
      expect_out("s2_model_exit_done", 0, 0, 0, 0, 3, 0);

      // Reservation delay with pause by clothes_add.
      pulse(2); pulse(2);
      expect_out("s3_order2", 0, 0, 0, 2, 3, 0);
      pulse(2); pulse(2);
      expect_out("s3_order_sat", 0, 0, 0, 3, 3, 0);
      toggle_start();
      expect_out("s3_delay", 0, 0, 1, 3, 3, 0);
      tick(0);
      pulse(1); expect_out("s3_clothes_pause", 0, 0, 2, 2, 3, 0);
      pulse(1); tick(0);
      expect_out("s3_pause_frozen", 0, 0, 2, 2, 3, 0);
      toggle_start();
      expect_out("s3_resume_delay", 0, 0, 1, 2, 3, 0);
      tick(0); tick(0);
      expect_out("s3_delay_end", 0, 0, 1, 0, 3, 0);
      tick(0); tick(0); tick(0);
      expect_out("s4_rinse", 0, 1, 1, 0, 2, 0);
      tick(1);
      expect_out("s4_pause_wins", 0, 1, 2, 0, 2, 0);
      toggle_start();
      expect_out("s4_resume", 0, 1, 1, 0, 2, 0);
      tick(0); tick(0); tick(0);
      expect_out("s5_mid_dry", 0, 2, 1, 0, 1, 0);
      @(negedge clk) power_light = 1'b0;
      cyc(4);
      expect_out("s5_power_off", 0, 0, 0, 0, 3, 0);
      toggle_start();
      expect_out("s5_power_off_ignore", 0, 0, 0, 0, 3, 0);
      @(negedge clk) power_light = 1'b1;
      cyc(5);

      // Async reset during DELAY.
      pulse(2);
      toggle_start();
      expect_out("s5_delay", 0, 0, 1, 1, 3, 0);
      @(posedge clk);
      #2 reset = 1'b0;
      expect_out("s5_async_reset", 0, 0, 0, 0, 3, 0);
      reset = 1'b1;
      cyc(5);
      expect_out("s5_after_reset", 0, 0, 0, 0, 3, 0);
      toggle_start();
      expect_out("s5_restart", 0, 0, 1, 0, 3, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
